// File: rtl/dtu_pmod_gpio.sv
// APB-controlled GPIO engine for the DTU PMOD pins: output/enable registers,
// synchronized inputs with per-pin rise/fall capture into a W1C status and a level IRQ.
module dtu_pmod_gpio #(
  parameter int WIDTH    = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic             clk_in,
  input  logic             reset_int,
  input  logic [31:0]      PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PWDATA,
  input  logic [3:0]       PSTRB,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic             irq_en_2,
  output logic             irq_2,
  input  logic [WIDTH-1:0] pmod_gpi,
  output logic [WIDTH-1:0] pmod_gpo,
  output logic [WIDTH-1:0] pmod_gpio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_OE      = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_RISE_EN = 3'd3;
  localparam logic [2:0] REG_FALL_EN = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  localparam logic [2:0] REG_OUT_SET = 3'd6;
  localparam logic [2:0] REG_OUT_CLR = 3'd7;

  state_t state_q, state_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             irq_q;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] gpi_s_q;
  logic [WIDTH-1:0] gpi_d_q;

  logic [2:0]       reg_sel;
  logic             addr_err;
  logic             done_cycle;
  logic             wr_en;
  logic [31:0]      strb_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_bits;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign reg_sel    = PADDR[ADDR_LSB+2:ADDR_LSB];
  assign addr_err   = |PADDR[31:ADDR_LSB+3];
  assign done_cycle = (state_q == ST_DONE);
  assign wr_en      = done_cycle & PSEL & PWRITE & ~addr_err;

  // One 8-bit lane per strobe; lanes beyond WIDTH simply fall off the slice below.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
      assign strb_mask[8*gi +: 8] = {8{PSTRB[gi]}};
    end
  endgenerate

  assign wmask = strb_mask[WIDTH-1:0];
  assign wbits = PWDATA[WIDTH-1:0] & wmask;

  // Only low bits of address/data are meaningful; fold the rest here.
  assign unused_ok = ^{PADDR, PWDATA, strb_mask};

  // ---------------------------------------------------------------- APB FSM
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Master dropping PSEL abandons the transfer without side effects.
        state_d = PSEL ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign PREADY  = done_cycle;
  assign PSLVERR = done_cycle & addr_err;
  assign PRDATA  = (done_cycle && !PWRITE && !addr_err) ? rdata : 32'd0;

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_OUT:     rdata[WIDTH-1:0] = out_q;
      REG_OE:      rdata[WIDTH-1:0] = oe_q;
      REG_IN:      rdata[WIDTH-1:0] = gpi_s_q;
      REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      REG_STATUS:  rdata[WIDTH-1:0] = status_q;
      default:     rdata = 32'd0;
    endcase
  end

  // ------------------------------------------------------- input sampling
  assign rise_w   = gpi_s_q & ~gpi_d_q;
  assign fall_w   = ~gpi_s_q & gpi_d_q;
  assign edge_set = (rise_w & rise_en_q) | (fall_w & fall_en_q);

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      sync1_q <= '0;
      gpi_s_q <= '0;
      gpi_d_q <= '0;
    end else begin
      sync1_q <= pmod_gpi;
      gpi_s_q <= sync1_q;
      gpi_d_q <= gpi_s_q;
    end
  end

  // ------------------------------------------------------- register file
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_bits  = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_OUT:     out_d     = (out_q & ~wmask) | wbits;
        REG_OE:      oe_d      = (oe_q & ~wmask) | wbits;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wbits;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wbits;
        REG_STATUS:  w1c_bits  = wbits;
        REG_OUT_SET: out_d     = out_q | wbits;
        REG_OUT_CLR: out_d     = out_q & ~wbits;
        default:     ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident event is never lost.
    status_d = (status_q & ~w1c_bits) | edge_set;
  end

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= irq_en_2 & (|status_q);
    end
  end

  assign irq_2        = irq_q;
  assign pmod_gpo     = out_q;
  assign pmod_gpio_oe = oe_q;

endmodule
